// File: rtl/vga_timing_pkg.sv
// Shared VGA timing defaults and the receiver lock-state encoding.
package vga_timing_pkg;
  localparam int H_ACTIVE_DEF    = 640;
  localparam int H_TOTAL_DEF     = 800;
  localparam int V_ACTIVE_DEF    = 480;
  localparam int V_TOTAL_DEF     = 525;
  localparam int COUNT_W_DEF     = 10;
  localparam int LOCK_FRAMES_DEF = 2;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    CHECK  = 2'd1,
    LOCKED = 2'd2
  } vga_state_e;
endpackage

// File: rtl/vga_edge_detect.sv
// Registers one sync input and flags the cycle where it rises.
module vga_edge_detect (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic sync_i,
  output logic rise_o
);
  logic sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) sync_q <= 1'b0;
    else         sync_q <= sync_i;
  end

  assign rise_o = sync_i & ~sync_q;
endmodule

// File: rtl/vga_sync_receiver.sv
// Recovers pixel coordinates from an H/V active-high sync pair, measures the
// incoming line/frame periods and tracks lock. state_o exposes the lock FSM.
module vga_sync_receiver
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE    = H_ACTIVE_DEF,
  parameter int H_TOTAL     = H_TOTAL_DEF,
  parameter int V_ACTIVE    = V_ACTIVE_DEF,
  parameter int V_TOTAL     = V_TOTAL_DEF,
  parameter int COUNT_W     = COUNT_W_DEF,
  parameter int LOCK_FRAMES = LOCK_FRAMES_DEF
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               H_pulse,
  input  logic               V_pulse,
  output logic [COUNT_W-1:0] col,
  output logic [COUNT_W-1:0] row,
  output logic               data_en,
  output logic               locked,
  output logic               sync_err,
  output logic [COUNT_W-1:0] line_len,
  output logic [COUNT_W-1:0] frame_len,
  output vga_state_e         state_o
);
  localparam logic [COUNT_W-1:0] CNT_MAX = '1;
  localparam logic [COUNT_W-1:0] H_ACT   = COUNT_W'(H_ACTIVE);
  localparam logic [COUNT_W-1:0] V_ACT   = COUNT_W'(V_ACTIVE);
  localparam logic [COUNT_W:0]   H_TOT   = (COUNT_W+1)'(H_TOTAL);
  localparam logic [COUNT_W:0]   V_TOT   = (COUNT_W+1)'(V_TOTAL);
  localparam logic [3:0]         LOCK_N  = 4'(LOCK_FRAMES);

  logic               h_rise, v_rise;
  logic [COUNT_W-1:0] col_q, col_d, row_q, row_d;
  logic [COUNT_W-1:0] line_len_q, line_len_d, frame_len_q, frame_len_d;
  logic               h_seen_q, h_seen_d, bad_line_q, bad_line_d;
  logic               sync_err_q, sync_err_d, data_en_q, data_en_d;
  logic [3:0]         good_q, good_d, good_inc;
  vga_state_e         state_q, state_d;
  logic [COUNT_W:0]   col_p1, row_p1;
  logic               line_meas, line_bad, frame_bad, timeout;

  vga_edge_detect u_h_edge (.clk_i(CLK), .rst_ni(RST_N), .sync_i(H_pulse), .rise_o(h_rise));
  vga_edge_detect u_v_edge (.clk_i(CLK), .rst_ni(RST_N), .sync_i(V_pulse), .rise_o(v_rise));

  // Measurements use the counts before this cycle's clear, one bit wider so a
  // saturated counter cannot wrap into a plausible period.
  assign col_p1    = {1'b0, col_q} + 1'b1;
  assign row_p1    = {1'b0, row_q} + 1'b1;
  assign line_meas = h_rise & h_seen_q;
  assign line_bad  = line_meas & (col_p1 != H_TOT);
  assign frame_bad = v_rise & (row_p1 != V_TOT);
  assign timeout   = (col_q == CNT_MAX);
  assign good_inc  = good_q + 4'd1;

  always_comb begin
    col_d       = (col_q == CNT_MAX) ? col_q : col_q + 1'b1;
    row_d       = row_q;
    line_len_d  = line_len_q;
    frame_len_d = frame_len_q;
    h_seen_d    = h_seen_q | h_rise;
    bad_line_d  = v_rise ? 1'b0 : (bad_line_q | line_bad);
    if (h_rise) begin
      col_d = '0;
      if (row_q != CNT_MAX) row_d = row_q + 1'b1;
    end
    if (v_rise)    row_d       = '0;
    if (line_meas) line_len_d  = col_p1[COUNT_W-1:0];
    if (v_rise)    frame_len_d = row_p1[COUNT_W-1:0];
  end

  always_comb begin
    state_d    = state_q;
    good_d     = good_q;
    sync_err_d = 1'b0;
    case (state_q)
      SEARCH: begin
        if (!timeout && v_rise && (h_seen_q || h_rise)) begin
          state_d = CHECK;
          good_d  = '0;
        end
      end
      CHECK: begin
        if (timeout) begin
          state_d = SEARCH;
        end else if (v_rise) begin
          // A frame counts only if no line in it was off-period.
          if (frame_bad || line_bad || bad_line_q) begin
            good_d = '0;
          end else begin
            good_d = good_inc;
            if (good_inc >= LOCK_N) state_d = LOCKED;
          end
        end else if (line_bad) begin
          good_d = '0;
        end
      end
      LOCKED: begin
        if (timeout || line_bad || frame_bad) begin
          sync_err_d = 1'b1;
          state_d    = SEARCH;
        end
      end
      default: state_d = SEARCH;
    endcase
    data_en_d = (state_d == LOCKED) && (col_d < H_ACT) && (row_d < V_ACT);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      col_q       <= '0;
      row_q       <= '0;
      line_len_q  <= '0;
      frame_len_q <= '0;
      h_seen_q    <= 1'b0;
      bad_line_q  <= 1'b0;
      sync_err_q  <= 1'b0;
      data_en_q   <= 1'b0;
      good_q      <= '0;
      state_q     <= SEARCH;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      line_len_q  <= line_len_d;
      frame_len_q <= frame_len_d;
      h_seen_q    <= h_seen_d;
      bad_line_q  <= bad_line_d;
      sync_err_q  <= sync_err_d;
      data_en_q   <= data_en_d;
      good_q      <= good_d;
      state_q     <= state_d;
    end
  end

  assign col       = col_q;
  assign row       = row_q;
  assign line_len  = line_len_q;
  assign frame_len = frame_len_q;
  assign sync_err  = sync_err_q;
  assign data_en   = data_en_q;
  assign locked    = (state_q == LOCKED);
  assign state_o   = state_q;
endmodule
